eof_intermission_tx: RTL and testbench
======================================

Name: eof_intermission_tx

Overview:
- Transmit-side companion to the channel's receive interframe detector.
- After the frame body and ACK delimiter, it drives the 7-bit recessive End-Of-Frame and the 3-bit Intermission.
- It reacts to an overload condition by transmitting an overload frame (flag + delimiter), then re-enters Intermission.
- It asserts txReady when the node may drive the next SOF. Sits between the bit-timing unit (txPulse/samplePulse) and the channel TX mux.

Parameters:
- EOF_BITS, 7, recessive EOF bits driven.
- INTER_BITS, 3, intermission bits.
- OVL_FLAG_BITS, 6, dominant overload flag bits.
- OVL_DELIM_BITS, 8, recessive overload delimiter bits, including the first recessive bit seen after the flag.

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- txPulse  in  1  one-cycle strobe at each bit start; txOut updates here
- samplePulse  in  1  sample strobe; 3 per bit if rateSelector=1, else 1
- rateSelector  in  1  1: 3-sample majority vote; 0: single sample
- dIn  in  1  bus value (1 = recessive)
- frameDone  in  1  one-cycle pulse after ACK delimiter sample; starts EOF
- startTx  in  1  one-cycle pulse; MAC consumes READY to send SOF
- txOut  out  1  driven bus value
- busy  out  1  sequence in progress
- txReady  out  1  EOF + intermission complete, bus free for SOF
- overloadActive  out  1  in overload flag, wait or delimiter
- bitError  out  1  one-cycle pulse, sequence aborted
- sofDetected  out  1  one-cycle pulse, dominant in last intermission bit

Behaviour:
- Clock and reset: one clock, clk; reset resetN is synchronous, active-low.
- Reset values: state IDLE, txOut=1, busy=0, txReady=0, overloadActive=0, bitError=0, sofDetected=0, counters 0, sampler idle.
  - Reset mid-sequence aborts it with no pulses.
  - First SOF after reset is gated by the receive interframe detector, not by this block.
- Sampler:
  - Counts samplePulse per bit.
  - rateSelector=1: bit value is the majority of 3 samples. rateSelector=0: bit value is the single sample.
  - bitValid fires one cycle after the final sample.
  - Sample count clears on txPulse.
- Bit gating:
  - An "armed" flag sets on txPulse and clears on bitValid.
  - A bit is evaluated only when bitValid fires while armed.
  - txPulse and samplePulse never coincide; this is guaranteed by the bit-timing unit and checked by assertion.
- txOut is registered and updated only on txPulse to the value the current state dictates: dominant (0) in OVL_FLAG, recessive (1) otherwise.
- State IDLE:
  - frameDone → EOF, bitCnt=0, armed cleared. The next txPulse begins EOF bit 1.
  - startTx is ignored.
- State EOF:
  - Each evaluated bit: recessive → bitCnt++; at bitCnt==EOF_BITS → INTER, bitCnt=0.
  - Dominant on any EOF bit → bitError pulse, go to IDLE.
- State INTER:
  - Recessive → bitCnt++; at INTER_BITS → READY.
  - Dominant on bit 1..INTER_BITS-1 → overload condition: go to OVL_FLAG, bitCnt=0; dominant driving starts at the next txPulse.
  - Dominant on the last bit → sofDetected pulse, go to IDLE; a foreign SOF means this node is a receiver.
- State OVL_FLAG:
  - Drives 0.
  - A sampled recessive while driving dominant → bitError, go to IDLE.
  - After OVL_FLAG_BITS evaluated bits → OVL_WAIT.
- State OVL_WAIT:
  - Drives 1.
  - Dominant bits (other nodes' flags) keep the state; the wait is unbounded.
  - First recessive bit → OVL_DELIM with bitCnt=1.
- State OVL_DELIM:
  - Recessive → bitCnt++; at OVL_DELIM_BITS → INTER, bitCnt=0.
  - Dominant → bitError, go to IDLE.
- State READY:
  - txReady=1, txOut=1.
  - startTx → IDLE; txReady drops the next cycle.
  - frameDone → EOF, the same as from IDLE.
  - Bus activity is not evaluated.
- Outputs:
  - busy=1 in EOF, INTER, OVL_*.
  - overloadActive=1 in OVL_*.
  - bitError and sofDetected are registered pulses, one cycle wide.
- Simultaneous events:
  - frameDone during any busy state is ignored.
  - frameDone and startTx in the same cycle in READY: frameDone wins.
  - bitValid arriving with armed=0 is discarded.
- Counters are sized clog2(max param + 1) and never wrap; transitions happen at equality.

Test Plan:
1. rateSelector=1, frameDone, 10 bits all recessive (3 samples each) → txOut=1 throughout; busy high 10 bits; txReady rises 1 cycle after the 10th bitValid; startTx → txReady=0 next cycle.
2. Dominant majority (samples 0,0,1) on EOF bit 4 → bitError pulse once; state IDLE; busy=0; txReady=0.
3. Dominant on intermission bit 2 → txOut=0 for exactly 6 txPulse periods; then recessive; overloadActive high. 2 extra dominant bits, then recessive → overload delimiter 8 bits total, then 3 intermission bits → txReady=1.
4. Dominant on intermission bit 3 → sofDetected pulse; IDLE; no overload; txReady=0.
5. rateSelector=0, single sample per bit; recessive sample during overload flag bit 3 → bitError; txOut returns to 1 on the next txPulse.
6. resetN=0 for 1 cycle mid-EOF (bit 5) → all outputs at reset values next cycle; a later frameDone restarts the full 7+3 sequence.

Source files
------------

// File: rtl/eof_intermission_tx_if.sv
// eof_intermission_tx_if
//   Bundles the bit-timing strobes, the sampled bus value, the MAC handshake
//   and the sequencer status outputs.
//   slave  : the sequencer (consumes strobes/handshake, drives status/txOut)
//   master : the environment (bit-timing unit, MAC, bus)
interface eof_intermission_tx_if;
  logic txPulse;
  logic samplePulse;
  logic rateSelector;
  logic dIn;
  logic frameDone;
  logic startTx;
  logic txOut;
  logic busy;
  logic txReady;
  logic overloadActive;
  logic bitError;
  logic sofDetected;

  modport slave (
    input  txPulse, samplePulse, rateSelector, dIn, frameDone, startTx,
    output txOut, busy, txReady, overloadActive, bitError, sofDetected
  );

  modport master (
    output txPulse, samplePulse, rateSelector, dIn, frameDone, startTx,
    input  txOut, busy, txReady, overloadActive, bitError, sofDetected
  );
endinterface

// File: rtl/eof_intermission_tx.sv
// eof_intermission_tx
//   Transmit-side End-Of-Frame / Intermission sequencer with overload-frame
//   handling. Drives 7 recessive EOF bits and 3 intermission bits after a
//   frame, answers an overload condition with flag + delimiter, and raises
//   txReady when the node may send the next SOF.
// Ports:
//   clk     : system clock
//   resetN  : synchronous active-low reset
//   bus     : eof_intermission_tx_if.slave
//             in : txPulse, samplePulse, rateSelector, dIn, frameDone, startTx
//             out: txOut, busy, txReady, overloadActive, bitError, sofDetected
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no sequence; waits for frameDone
// S_EOF      | counting recessive End-Of-Frame bits
// S_INTER    | counting recessive intermission bits
// S_OVL_FLAG | driving the dominant overload flag
// S_OVL_WAIT | recessive, waiting out other nodes' overload flags
// S_OVL_DELIM| counting recessive overload delimiter bits
// S_READY    | bus free, txReady high until startTx or frameDone
module eof_intermission_tx #(
  parameter int EOF_BITS       = 7,
  parameter int INTER_BITS     = 3,
  parameter int OVL_FLAG_BITS  = 6,
  parameter int OVL_DELIM_BITS = 8
) (
  input logic                  clk,
  input logic                  resetN,
  eof_intermission_tx_if.slave bus
);

  localparam int MAX_A   = (EOF_BITS > INTER_BITS) ? EOF_BITS : INTER_BITS;
  localparam int MAX_B   = (OVL_FLAG_BITS > OVL_DELIM_BITS) ? OVL_FLAG_BITS : OVL_DELIM_BITS;
  localparam int MAX_ALL = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] EOF_N   = CW'(EOF_BITS);
  localparam logic [CW-1:0] INTER_N = CW'(INTER_BITS);
  localparam logic [CW-1:0] FLAG_N  = CW'(OVL_FLAG_BITS);
  localparam logic [CW-1:0] DELIM_N = CW'(OVL_DELIM_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_EOF, S_INTER, S_OVL_FLAG, S_OVL_WAIT, S_OVL_DELIM, S_READY
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]    samp_cnt_q, ones_q;
  logic          bit_valid_q, bit_val_q;
  logic          armed_q, armed_d, clr_armed;
  logic          tx_out_q, busy_q, ready_q, ovl_q, err_q, sof_q;
  logic          err_d, sof_d;
  logic          final_samp, bit_now, eval;

  // The last strobe of a bit: 3rd with majority voting, 1st otherwise.
  // samp_cnt saturates at 3 so stray extra strobes never re-fire it.
  assign final_samp = bus.samplePulse &&
                      (bus.rateSelector ? (samp_cnt_q == 2'd2) : (samp_cnt_q == 2'd0));
  assign bit_now    = bus.rateSelector ?
                      (({1'b0, ones_q} + {2'b00, bus.dIn}) >= 3'd2) : bus.dIn;
  assign eval       = bit_valid_q && armed_q;
  assign cnt_inc    = cnt_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    sof_d     = 1'b0;
    clr_armed = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.frameDone) begin
          state_d   = S_EOF;
          cnt_d     = '0;
          clr_armed = 1'b1;
        end
      end
      S_READY: begin
        // frameDone has priority over startTx
        if (bus.frameDone) begin
          state_d   = S_EOF;
          cnt_d     = '0;
          clr_armed = 1'b1;
        end else if (bus.startTx) begin
          state_d = S_IDLE;
        end
      end
      S_EOF: begin
        if (eval) begin
          if (!bit_val_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == EOF_N) begin
            state_d = S_INTER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_INTER: begin
        if (eval) begin
          if (!bit_val_q) begin
            // dominant on the last intermission bit is a foreign SOF
            if (cnt_inc == INTER_N) begin
              sof_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_OVL_FLAG;
            end
            cnt_d = '0;
          end else if (cnt_inc == INTER_N) begin
            state_d = S_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_OVL_FLAG: begin
        if (eval) begin
          if (bit_val_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == FLAG_N) begin
            state_d = S_OVL_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_OVL_WAIT: begin
        // first recessive bit already counts as delimiter bit 1
        if (eval && bit_val_q) begin
          state_d = S_OVL_DELIM;
          cnt_d   = CW'(1);
        end
      end
      S_OVL_DELIM: begin
        if (eval) begin
          if (!bit_val_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == DELIM_N) begin
            state_d = S_INTER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (clr_armed)          armed_d = 1'b0;
    else if (bus.txPulse)   armed_d = 1'b1;
    else if (bit_valid_q)   armed_d = 1'b0;
    else                    armed_d = armed_q;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      samp_cnt_q  <= '0;
      ones_q      <= '0;
      bit_valid_q <= 1'b0;
      bit_val_q   <= 1'b1;
      armed_q     <= 1'b0;
      tx_out_q    <= 1'b1;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      ovl_q       <= 1'b0;
      err_q       <= 1'b0;
      sof_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;

      if (bus.txPulse) begin
        samp_cnt_q <= '0;
        ones_q     <= '0;
      end else if (bus.samplePulse && (samp_cnt_q != 2'd3)) begin
        samp_cnt_q <= samp_cnt_q + 2'd1;
        ones_q     <= ones_q + {1'b0, bus.dIn};
      end
      bit_valid_q <= final_samp;
      if (final_samp) bit_val_q <= bit_now;

      // txOut follows the state present at the bit start
      if (bus.txPulse) tx_out_q <= (state_q != S_OVL_FLAG);

      busy_q  <= (state_d != S_IDLE) && (state_d != S_READY);
      ready_q <= (state_d == S_READY);
      ovl_q   <= (state_d == S_OVL_FLAG) || (state_d == S_OVL_WAIT) ||
                 (state_d == S_OVL_DELIM);
      err_q   <= err_d;
      sof_q   <= sof_d;
    end
  end

  assign bus.txOut          = tx_out_q;
  assign bus.busy           = busy_q;
  assign bus.txReady        = ready_q;
  assign bus.overloadActive = ovl_q;
  assign bus.bitError       = err_q;
  assign bus.sofDetected    = sof_q;

  // The bit-timing unit never issues both strobes in one cycle.
  a_strobe_exclusive: assert property (@(posedge clk) disable iff (!resetN)
    !(bus.txPulse && bus.samplePulse));

endmodule

// File: tb/tb_eof_intermission_tx.sv
module tb_eof_intermission_tx;
  localparam int EOF_BITS = 7, INTER_BITS = 3, FLAG_BITS = 6, DELIM_BITS = 8;
  localparam int PH_IDLE = 0, PH_EOF = 1, PH_INTER = 2, PH_FLAG = 3,
                 PH_WAIT = 4, PH_DELIM = 5, PH_READY = 6;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  eof_intermission_tx_if bus();
  eof_intermission_tx dut (.clk(clk), .resetN(resetN), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct packed {logic txo; logic bsy; logic ovl;} bitexp_t;
  bitexp_t exp_q[$];
  byte     ev_q[$];

  // Reference model: phase plus number of bits still required in it.
  int m_phase = PH_IDLE;
  int m_left  = 0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic bit m_busy();
    return (m_phase != PH_IDLE) && (m_phase != PH_READY);
  endfunction

  function automatic bit m_ovl();
    return (m_phase == PH_FLAG) || (m_phase == PH_WAIT) || (m_phase == PH_DELIM);
  endfunction

  function automatic void m_abort(input byte ev);
    ev_q.push_back(ev);
    m_phase = PH_IDLE;
  endfunction

  function automatic void model_eval(input bit v);
    case (m_phase)
      PH_EOF:
        if (!v) m_abort("E");
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = PH_INTER; m_left = INTER_BITS; end
        end
      PH_INTER:
        if (!v) begin
          if (m_left == 1) m_abort("S");
          else begin m_phase = PH_FLAG; m_left = FLAG_BITS; end
        end else begin
          m_left--;
          if (m_left == 0) begin m_phase = PH_READY; ev_q.push_back("R"); end
        end
      PH_FLAG:
        if (v) m_abort("E");
        else begin
          m_left--;
          if (m_left == 0) m_phase = PH_WAIT;
        end
      PH_WAIT:
        if (v) begin m_phase = PH_DELIM; m_left = DELIM_BITS - 1; end
      PH_DELIM:
        if (!v) m_abort("E");
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = PH_INTER; m_left = INTER_BITS; end
        end
      default: ;
    endcase
  endfunction

  function automatic void ev_check(input byte got);
    byte req;
    if (ev_q.size() == 0) chk("spurious_event", int'(got), 0);
    else begin
      req = ev_q.pop_front();
      chk("event_kind", int'(got), int'(req));
    end
  endfunction

  // Monitor: compares bit-start outputs and status events against the queues.
  initial begin : monitor
    logic tp;
    logic prev_rdy;
    bitexp_t e;
    prev_rdy = 1'b0;
    forever begin
      @(posedge clk);
      tp = bus.txPulse;
      #1;
      if (!resetN) begin
        prev_rdy = 1'b0;
        continue;
      end
      if (tp) begin
        if (exp_q.size() == 0) chk("unexpected_txpulse_entry", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("txOut_at_bit_start", int'(bus.txOut), int'(e.txo));
          chk("busy_at_bit_start", int'(bus.busy), int'(e.bsy));
          chk("overloadActive_at_bit_start", int'(bus.overloadActive), int'(e.ovl));
        end
      end
      if (bus.bitError)               ev_check("E");
      if (bus.sofDetected)            ev_check("S");
      if (bus.txReady && !prev_rdy)   ev_check("R");
      if (!bus.txReady && prev_rdy)   ev_check("r");
      prev_rdy = bus.txReady;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ctl(input bit fd, input bit st);
    bus.frameDone = fd;
    bus.startTx   = st;
    if (fd && (m_phase == PH_IDLE || m_phase == PH_READY)) begin
      if (m_phase == PH_READY) ev_q.push_back("r");
      m_phase = PH_EOF;
      m_left  = EOF_BITS;
    end else if (st && m_phase == PH_READY) begin
      ev_q.push_back("r");
      m_phase = PH_IDLE;
    end
    tick();
    bus.frameDone = 1'b0;
    bus.startTx   = 1'b0;
    tick();
  endtask

  task automatic pulse_tx();
    bitexp_t e;
    e.txo = (m_phase != PH_FLAG);
    e.bsy = m_busy();
    e.ovl = m_ovl();
    exp_q.push_back(e);
    bus.txPulse = 1'b1;
    tick();
    bus.txPulse = 1'b0;
  endtask

  // One bit: txPulse, then 3 (or 1) samples; s[0] is the first sample.
  task automatic do_bit(input bit rate, input logic [2:0] s);
    int n;
    bit v;
    bus.rateSelector = rate;
    n = rate ? 3 : 1;
    v = rate ? ($countones(s) >= 2) : s[0];
    pulse_tx();
    repeat (2) tick();
    for (int i = 0; i < n; i++) begin
      bus.dIn = s[i];
      bus.samplePulse = 1'b1;
      if (i == n - 1) model_eval(v);
      tick();
      bus.samplePulse = 1'b0;
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic rec_bits(input bit rate, input int n);
    for (int i = 0; i < n; i++) do_bit(rate, 3'b111);
  endtask

  function automatic logic [2:0] gen_samples(input bit rate, input bit v);
    logic [2:0] s;
    s = {v, v, v};
    if (rate && ($urandom_range(0, 2) == 0)) s[$urandom_range(0, 2)] = ~v;
    return s;
  endfunction

  function automatic bit gen_value();
    case (m_phase)
      PH_FLAG: return ($urandom_range(0, 15) == 0);
      PH_WAIT: return ($urandom_range(0, 2) != 0);
      default: return ($urandom_range(0, 9) != 0);
    endcase
  endfunction

  task automatic check_status(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), int'(m_busy()));
    chk({tag, "_txReady"}, int'(bus.txReady), int'(m_phase == PH_READY));
    chk({tag, "_overloadActive"}, int'(bus.overloadActive), int'(m_ovl()));
  endtask

  initial begin : stimulus
    bit rate;
    bus.txPulse = 0; bus.samplePulse = 0; bus.rateSelector = 1; bus.dIn = 1;
    bus.frameDone = 0; bus.startTx = 0;
    repeat (3) tick();
    chk("reset_txOut", int'(bus.txOut), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_txReady", int'(bus.txReady), 0);
    chk("reset_overloadActive", int'(bus.overloadActive), 0);
    chk("reset_bitError", int'(bus.bitError), 0);
    chk("reset_sofDetected", int'(bus.sofDetected), 0);
    resetN = 1'b1;
    tick();

    // 1: clean EOF + intermission, then startTx
    ctl(1, 0);
    rec_bits(1, EOF_BITS + INTER_BITS);
    check_status("t1_ready");
    ctl(0, 1);
    check_status("t1_after_start");

    // 2: dominant majority on EOF bit 4 (samples 0,0,1)
    ctl(1, 0);
    rec_bits(1, 3);
    do_bit(1, 3'b100);
    check_status("t2_after_error");

    // 3: overload from intermission bit 2, two foreign flag bits, delimiter
    ctl(1, 0);
    rec_bits(1, EOF_BITS + 1);
    do_bit(1, 3'b000);
    for (int i = 0; i < FLAG_BITS + 2; i++) do_bit(1, 3'b000);
    check_status("t3_in_wait");
    rec_bits(1, DELIM_BITS + INTER_BITS);
    check_status("t3_ready");

    // 4: dominant on last intermission bit -> foreign SOF
    ctl(1, 0);
    rec_bits(1, EOF_BITS + 2);
    do_bit(1, 3'b010);
    check_status("t4_after_sof");

    // 5: single sample, recessive during overload flag bit 3
    ctl(1, 0);
    rec_bits(0, EOF_BITS + 1);
    do_bit(0, 3'b000);
    do_bit(0, 3'b000);
    do_bit(0, 3'b000);
    do_bit(0, 3'b111);
    do_bit(0, 3'b111);
    check_status("t5_after_error");

    // 6: reset during EOF bit 5
    ctl(1, 0);
    rec_bits(1, 4);
    pulse_tx();
    repeat (2) tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    m_phase = PH_IDLE;
    chk("t6_txOut", int'(bus.txOut), 1);
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_overloadActive", int'(bus.overloadActive), 0);
    chk("t6_bitError", int'(bus.bitError), 0);
    tick();
    ctl(1, 0);
    rec_bits(1, EOF_BITS + INTER_BITS);
    check_status("t6_ready");
    ctl(1, 1);
    check_status("t6_fd_wins");
    rec_bits(1, EOF_BITS + INTER_BITS);

    // randomized sequences
    for (int t = 0; t < 40; t++) begin
      rate = bit'($urandom_range(0, 1));
      ctl(1, bit'($urandom_range(0, 3) == 0));
      for (int b = 0; b < 40 && m_busy(); b++) begin
        bit v;
        v = gen_value();
        do_bit(rate, gen_samples(rate, v));
        if ($urandom_range(0, 15) == 0) ctl(1, 0);
      end
      for (int b = 0; b < 20 && m_busy(); b++)
        do_bit(rate, gen_samples(rate, m_phase != PH_FLAG));
      check_status("rand_end");
      case ($urandom_range(0, 2))
        0: ctl(0, 1);
        1: ctl(1, 1);
        default: ;
      endcase
    end

    repeat (5) tick();
    chk("bit_queue_drained", exp_q.size(), 0);
    chk("event_queue_drained", ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
